// File: rtl/data_memory_arbiter.sv
// Two-port arbiter in front of a single-ported DataMemory: the processor and the
// debug loader share it, with burst-limited round-robin when both request.
module data_memory_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int MAX_BURST  = 4,
  localparam int CNT_W     = (MAX_BURST < 1) ? 1 : $clog2(MAX_BURST + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  input  logic                  dbg_req,
  input  logic                  dbg_we,
  input  logic [ADDR_WIDTH-1:0] dbg_addr,
  input  logic [DATA_WIDTH-1:0] dbg_wdata,
  output logic                  cpu_gnt,
  output logic                  dbg_gnt,
  output logic                  cpu_rvalid,
  output logic                  dbg_rvalid,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  output logic [DATA_WIDTH-1:0] dbg_rdata,
  output logic                  mem_we,
  output logic                  mem_re,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [1:0]            stateDbg,
  output logic [CNT_W-1:0]      burstCntDbg
);

  // Handshake: an access is accepted in exactly the cycle where req=1 and gnt=1;
  // gnt is combinational and never waits on anything but the arbitration rules.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CPU  = 2'd1,
    DBG  = 2'd2
  } ownerE;

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BURST);
  localparam logic [CNT_W-1:0] ONE_CNT = CNT_W'(1);

  ownerE            state;
  ownerE            stateNext;
  logic [CNT_W-1:0] burstCnt;
  logic [CNT_W-1:0] burstNext;
  logic [CNT_W-1:0] burstInc;
  logic             cpuWin;
  logic             dbgWin;
  logic             cpuRvalidQ;
  logic             dbgRvalidQ;

  assign burstInc = (burstCnt >= MAX_CNT) ? MAX_CNT : burstCnt + ONE_CNT;

  // Arbitration and next owner
  always_comb begin
    cpuWin    = 1'b0;
    dbgWin    = 1'b0;
    stateNext = IDLE;
    burstNext = '0;
    if (!reset) begin
      if (cpu_req && !dbg_req) begin
        cpuWin = 1'b1;
      end else if (dbg_req && !cpu_req) begin
        dbgWin = 1'b1;
      end else if (cpu_req && dbg_req) begin
        case (state)
          CPU: begin
            if (burstCnt < MAX_CNT) cpuWin = 1'b1;
            else                    dbgWin = 1'b1;
          end
          DBG: begin
            if (burstCnt < MAX_CNT) dbgWin = 1'b1;
            else                    cpuWin = 1'b1;
          end
          default: cpuWin = 1'b1;
        endcase
      end
    end
    if (cpuWin) begin
      stateNext = CPU;
      burstNext = (state == CPU) ? burstInc : ONE_CNT;
    end else if (dbgWin) begin
      stateNext = DBG;
      burstNext = (state == DBG) ? burstInc : ONE_CNT;
    end
  end

  // Memory port mux: idle cycles drive all zeros so the bus is quiet
  always_comb begin
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (cpuWin) begin
      mem_we    = cpu_we;
      mem_re    = !cpu_we;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
    end else if (dbgWin) begin
      mem_we    = dbg_we;
      mem_re    = !dbg_we;
      mem_addr  = dbg_addr;
      mem_wdata = dbg_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      burstCnt   <= '0;
      cpuRvalidQ <= 1'b0;
      dbgRvalidQ <= 1'b0;
    end else begin
      state      <= stateNext;
      burstCnt   <= burstNext;
      cpuRvalidQ <= cpuWin && !cpu_we;
      dbgRvalidQ <= dbgWin && !dbg_we;
    end
  end

  // rvalid is also masked by a live reset so a read accepted just before reset never returns
  assign cpu_gnt     = cpuWin;
  assign dbg_gnt     = dbgWin;
  assign cpu_rvalid  = cpuRvalidQ && !reset;
  assign dbg_rvalid  = dbgRvalidQ && !reset;
  assign cpu_rdata   = cpu_rvalid ? mem_rdata : '0;
  assign dbg_rdata   = dbg_rvalid ? mem_rdata : '0;
  assign stateDbg    = state;
  assign burstCntDbg = burstCnt;

endmodule

// File: tb/tb_data_memory_arbiter.sv
// Bench for data_memory_arbiter: directed scenarios with literal expectations plus
// a per-cycle reference model of the arbitration rules and read pipeline.
module tb_data_memory_arbiter;

  localparam int DW  = 32;
  localparam int AW  = 10;
  localparam int MAXB = 4;
  localparam int CW  = $clog2(MAXB + 1);

  logic          clk;
  logic          reset;
  logic          cpu_req, cpu_we, dbg_req, dbg_we;
  logic [AW-1:0] cpu_addr, dbg_addr;
  logic [DW-1:0] cpu_wdata, dbg_wdata;
  logic          cpu_gnt, dbg_gnt, cpu_rvalid, dbg_rvalid;
  logic [DW-1:0] cpu_rdata, dbg_rdata;
  logic          mem_we, mem_re;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic [1:0]    stateDbg;
  logic [CW-1:0] burstCntDbg;

  int checks = 0;
  int errors = 0;

  data_memory_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_BURST(MAXB)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .cpu_gnt(cpu_gnt), .dbg_gnt(dbg_gnt),
    .cpu_rvalid(cpu_rvalid), .dbg_rvalid(dbg_rvalid),
    .cpu_rdata(cpu_rdata), .dbg_rdata(dbg_rdata),
    .mem_we(mem_we), .mem_re(mem_re), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .stateDbg(stateDbg), .burstCntDbg(burstCntDbg)
  );

  // ---------------- clock / reset / memory ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, expected end of stimulus");
    $fatal(1);
  end

  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic [DW-1:0] shadow [0:(1<<AW)-1];

  initial begin
    for (int i = 0; i < (1 << AW); i++) begin
      mem[i]    = 32'h1000_0000 + i * 7;
      shadow[i] = 32'h1000_0000 + i * 7;
    end
    mem[1] = 32'h11; shadow[1] = 32'h11;
    mem[2] = 32'h22; shadow[2] = 32'h22;
    mem_rdata = '0;
  end

  // Write-first synchronous DataMemory with one-cycle read latency
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    if (mem_re) mem_rdata <= mem[mem_addr];
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model + compare ----------------
  int owner = 0;             // 0 none, 1 processor, 2 debug loader
  int run   = 0;             // consecutive accepted accesses by owner
  logic [DW:0] expQ[$];      // {isDbg, data} of read beats due next cycle

  always @(negedge clk) begin : compare
    int            win;
    logic [DW:0]   beat;
    logic          eCv, eDv, eWe, eRe;
    logic [DW-1:0] eCd, eDd, eWd;
    logic [AW-1:0] eAddr;
    win = 0;
    if (!reset) begin
      if (cpu_req && !dbg_req)      win = 1;
      else if (dbg_req && !cpu_req) win = 2;
      else if (cpu_req && dbg_req)  win = (owner == 0) ? 1 : ((run < MAXB) ? owner : 3 - owner);
    end
    eWe = 1'b0; eRe = 1'b0; eAddr = '0; eWd = '0;
    if (win == 1) begin eWe = cpu_we; eRe = !cpu_we; eAddr = cpu_addr; eWd = cpu_wdata; end
    if (win == 2) begin eWe = dbg_we; eRe = !dbg_we; eAddr = dbg_addr; eWd = dbg_wdata; end
    eCv = 1'b0; eDv = 1'b0; eCd = '0; eDd = '0;
    if (!reset && expQ.size() > 0) begin
      beat = expQ.pop_front();
      if (beat[DW]) begin eDv = 1'b1; eDd = beat[DW-1:0]; end
      else          begin eCv = 1'b1; eCd = beat[DW-1:0]; end
    end
    check("cpu_gnt", 64'(cpu_gnt), 64'(win == 1));
    check("dbg_gnt", 64'(dbg_gnt), 64'(win == 2));
    check("one_gnt", 64'(cpu_gnt && dbg_gnt), 64'd0);
    check("mem_we", 64'(mem_we), 64'(eWe));
    check("mem_re", 64'(mem_re), 64'(eRe));
    check("mem_addr", 64'(mem_addr), 64'(eAddr));
    check("mem_wdata", 64'(mem_wdata), 64'(eWd));
    check("cpu_rvalid", 64'(cpu_rvalid), 64'(eCv));
    check("cpu_rdata", 64'(cpu_rdata), 64'(eCd));
    check("dbg_rvalid", 64'(dbg_rvalid), 64'(eDv));
    check("dbg_rdata", 64'(dbg_rdata), 64'(eDd));
    check("owner", 64'(stateDbg), 64'(owner));
    check("burst_cnt", 64'(burstCntDbg), 64'(run));
    if (reset) begin
      owner = 0; run = 0; expQ.delete();
    end else begin
      if (win == 1 && !cpu_we) expQ.push_back({1'b0, shadow[cpu_addr]});
      if (win == 2 && !dbg_we) expQ.push_back({1'b1, shadow[dbg_addr]});
      if (win == 1 && cpu_we) shadow[cpu_addr] = cpu_wdata;
      if (win == 2 && dbg_we) shadow[dbg_addr] = dbg_wdata;
      if (win != 0) begin
        run   = (owner == win) ? ((run < MAXB) ? run + 1 : MAXB) : 1;
        owner = win;
      end else begin
        owner = 0; run = 0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Applies one cycle of inputs just after the rising edge and returns at the falling edge
  task automatic cyc(input logic rst,
                     input logic cr, input logic cw, input int ca, input logic [DW-1:0] cd,
                     input logic dr, input logic dw, input int da, input logic [DW-1:0] dd);
    @(posedge clk);
    #1;
    reset = rst;
    cpu_req = cr; cpu_we = cw; cpu_addr = AW'(ca); cpu_wdata = cd;
    dbg_req = dr; dbg_we = dw; dbg_addr = AW'(da); dbg_wdata = dd;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, '0, 0, 0, 0, '0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b1;
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    dbg_req = 0; dbg_we = 0; dbg_addr = '0; dbg_wdata = '0;

    // Requests during reset are ignored
    for (int i = 0; i < 3; i++) begin
      cyc(1, 1, 1, 3, 32'hAAAA, 1, 0, 4, '0);
      check("rst_cpu_gnt", 64'(cpu_gnt), 64'd0);
      check("rst_mem_we", 64'(mem_we), 64'd0);
    end
    idle(1);
    check("rst_owner_idle", 64'(stateDbg), 64'd0);

    // Processor write then read of address 5
    cyc(0, 1, 1, 5, 32'hDEADBEEF, 0, 0, 0, '0);
    check("wr5_gnt", 64'(cpu_gnt), 64'd1);
    check("wr5_mem_we", 64'(mem_we), 64'd1);
    cyc(0, 1, 0, 5, '0, 0, 0, 0, '0);
    check("rd5_gnt", 64'(cpu_gnt), 64'd1);
    check("rd5_mem_re", 64'(mem_re), 64'd1);
    idle(1);
    check("rd5_rvalid", 64'(cpu_rvalid), 64'd1);
    check("rd5_rdata", 64'(cpu_rdata), 64'hDEADBEEF);
    check("rd5_dbg_rvalid", 64'(dbg_rvalid), 64'd0);

    // Short processor burst, then three quiet cycles return to idle
    for (int i = 0; i < 3; i++) cyc(0, 1, 0, 10 + i, '0, 0, 0, 0, '0);
    idle(3);
    check("quiet_owner", 64'(stateDbg), 64'd0);
    check("quiet_burst", 64'(burstCntDbg), 64'd0);

    // Continuous contention: four grants each, alternating, starting with the processor
    for (int i = 0; i < 12; i++) begin
      cyc(0, 1, 0, 20 + i, '0, 1, 0, 40 + i, '0);
      check("rr_cpu_gnt", 64'(cpu_gnt), 64'(((i / 4) % 2) == 0));
      check("rr_dbg_gnt", 64'(dbg_gnt), 64'(((i / 4) % 2) == 1));
    end
    idle(2);

    // Processor owns with two beats, drops its request for one cycle
    cyc(0, 1, 0, 6, '0, 1, 0, 7, '0);
    cyc(0, 1, 0, 6, '0, 1, 0, 7, '0);
    check("hold_burst2", 64'(burstCntDbg), 64'd1);
    cyc(0, 0, 0, 6, '0, 1, 0, 7, '0);
    check("drop_dbg_gnt", 64'(dbg_gnt), 64'd1);
    cyc(0, 1, 0, 6, '0, 1, 0, 7, '0);
    check("drop_owner", 64'(stateDbg), 64'd2);
    check("drop_burst", 64'(burstCntDbg), 64'd1);
    idle(2);

    // Alternating single-requester reads stream with no bubble
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 0) cyc(0, 1, 0, 1, '0, 0, 0, 0, '0);
      else            cyc(0, 0, 0, 0, '0, 1, 0, 2, '0);
      if (i > 0 && (i % 2) == 1) begin
        check("alt_cpu_rvalid", 64'(cpu_rvalid), 64'd1);
        check("alt_cpu_rdata", 64'(cpu_rdata), 64'h11);
        check("alt_dbg_quiet", 64'(dbg_rvalid), 64'd0);
      end else if (i > 0) begin
        check("alt_dbg_rvalid", 64'(dbg_rvalid), 64'd1);
        check("alt_dbg_rdata", 64'(dbg_rdata), 64'h22);
      end
    end
    idle(1);
    check("alt_last_dbg", 64'(dbg_rdata), 64'h22);

    // Debug read followed by reset: the read never returns
    idle(1);
    cyc(0, 0, 0, 0, '0, 1, 0, 2, '0);
    check("prerst_dbg_gnt", 64'(dbg_gnt), 64'd1);
    cyc(1, 0, 0, 0, '0, 0, 0, 0, '0);
    check("rst_dbg_rvalid", 64'(dbg_rvalid), 64'd0);
    check("rst_dbg_rdata", 64'(dbg_rdata), 64'd0);
    cyc(1, 1, 0, 3, '0, 1, 0, 4, '0);
    check("rst_gnt_held", 64'(cpu_gnt), 64'd0);
    cyc(0, 1, 0, 3, '0, 1, 0, 4, '0);
    check("postrst_cpu_gnt", 64'(cpu_gnt), 64'd1);
    check("postrst_no_rvalid", 64'(dbg_rvalid), 64'd0);
    idle(1);

    // Debug write then immediate read of the same address
    cyc(0, 0, 0, 0, '0, 1, 1, 9, 32'h12345678);
    cyc(0, 0, 0, 0, '0, 1, 0, 9, '0);
    idle(1);
    check("wr_rd_dbg_rdata", 64'(dbg_rdata), 64'h12345678);

    // Mixed traffic, checked cycle by cycle against the model
    for (int i = 0; i < 60; i++) begin
      cyc(0,
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 15), $urandom,
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 15), $urandom);
    end
    idle(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/data_memory_arbiter.md
DATA_MEMORY_ARBITER -- requirements
Module: data_memory_arbiter

Interface
- REQ-001: Parameter DATA_WIDTH, 32, data word width.
- REQ-002: Parameter ADDR_WIDTH, 10, word address width (1024-word DataMemory).
- REQ-003: Parameter MAX_BURST, 4, max consecutive accesses by one requester under contention; legal range >= 1.
- REQ-004: clk  input  1  single clock; all state updates on rising edge.
- REQ-005: reset  input  1  synchronous, active-high reset.
- REQ-006: cpu_req, dbg_req  input  1  access request from processor / debug-loader port.
- REQ-007: cpu_we, dbg_we  input  1  1 = write, 0 = read; valid while req=1.
- REQ-008: cpu_addr, dbg_addr  input  ADDR_WIDTH  word address; valid while req=1.
- REQ-009: cpu_wdata, dbg_wdata  input  DATA_WIDTH  write data; valid while req=1 and we=1.
- REQ-010: cpu_gnt, dbg_gnt  output  1  combinational grant; access accepted in cycle where req=1 and gnt=1.
- REQ-011: cpu_rvalid, dbg_rvalid  output  1  registered read-data-valid.
- REQ-012: cpu_rdata, dbg_rdata  output  DATA_WIDTH  read data, qualified by rvalid.
- REQ-013: mem_we, mem_re  output  1  write / read strobe to DataMemory.
- REQ-014: mem_addr  output  ADDR_WIDTH  DataMemory word address.
- REQ-015: mem_wdata  output  DATA_WIDTH  DataMemory write data.
- REQ-016: mem_rdata  input  DATA_WIDTH  DataMemory read data, valid one cycle after mem_re.

Function
- REQ-017: Owner FSM SHALL have states IDLE, CPU, DBG, plus burst counter burst_cnt (0..MAX_BURST).
- REQ-018: At most one of cpu_gnt/dbg_gnt SHALL be 1 in any cycle; gnt=0 when corresponding req=0.
- REQ-019: Only one requester active -> that requester granted, regardless of state or burst_cnt.
- REQ-020: Both requesting, state IDLE -> CPU granted.
- REQ-021: Both requesting, state = owner X -> X granted if burst_cnt < MAX_BURST, else the other requester granted.
- REQ-022: Accepted access by X: state <= X; burst_cnt <= burst_cnt+1 if X was already owner, else 1; burst_cnt saturates at MAX_BURST.
- REQ-023: No accepted access in a cycle -> state <= IDLE, burst_cnt <= 0.
- REQ-024: Accepted access SHALL drive mem_addr/mem_wdata from winner same cycle; mem_we = winner we; mem_re = not winner we.
- REQ-025: No accepted access -> mem_we=0, mem_re=0, mem_addr=0, mem_wdata=0.
- REQ-026: Accepted read at cycle N -> winner rvalid=1 in cycle N+1 only, rdata = mem_rdata that cycle; fixed latency 1.
- REQ-027: rdata outputs SHALL be 0 when corresponding rvalid=0; other requester's rvalid stays 0.
- REQ-028: Back-to-back reads (one per cycle, either requester) SHALL be fully pipelined, no bubble.
- REQ-029: Writes produce no rvalid; write-then-read same address in consecutive cycles returns written data (DataMemory write-first on next read).
- REQ-030: Requester may drop req any cycle; no penalty, no pending state retained.

Reset
- REQ-031: reset=1 at clock edge -> state IDLE, burst_cnt 0, cpu_rvalid=dbg_rvalid=0 next cycle.
- REQ-032: While reset=1: gnt outputs 0, mem_we/mem_re 0, rdata 0; requests ignored.
- REQ-033: Reset asserted in cycle after accepted read -> that rvalid suppressed; no late rvalid after reset release.

Verification
- REQ-034: Only cpu_req, write addr 5 data 0xDEADBEEF, then read addr 5 -> cpu_gnt=1 both cycles; mem_we=1 then mem_re=1; cpu_rvalid=1 next cycle, cpu_rdata=0xDEADBEEF; dbg_rvalid stays 0.
- REQ-035: Both req held continuously from IDLE, MAX_BURST=4 -> grants CPU x4, DBG x4, CPU x4, ...; never two gnt high together.
- REQ-036: Both req, CPU owner with burst_cnt=2, cpu_req drops one cycle -> DBG granted that cycle, DBG owner, burst_cnt=1.
- REQ-037: Alternating reads CPU addr 1 / DBG addr 2 every cycle, mem holds 0x11/0x22 -> cpu_rvalid/dbg_rvalid alternate each cycle with 0x11/0x22, no bubble.
- REQ-038: Accepted DBG read, reset=1 next edge -> dbg_rvalid=0 thereafter, state IDLE; first post-reset contention grants CPU.
- REQ-039: No requests 3 cycles after CPU burst -> state IDLE, burst_cnt 0; mem_we=mem_re=0 throughout.
